// File: rtl/au_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au_seq_pkg                                                         |
// | Shared constants, op encodings and FSM state type for the          |
// | au_seq_ctrl add/subtract/multiply sequencer.                       |
// | Revision: 1.0  initial release                                     |
// +------------------------------------------------------------------+
package au_seq_pkg;

  localparam int WIDTH     = 6;
  localparam int MUL_ITERS = 6;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/au6_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au6_addsub                                                         |
// | WIDTH-bit ripple-carry add/subtract unit. sub inverts b; the       |
// | caller supplies carry-in (1 for a true subtract).                  |
// | c_msb is the carry into the MSB, used for signed overflow.         |
// | Revision: 1.0  initial release                                     |
// +------------------------------------------------------------------+
module au6_addsub #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign c[0]  = cin;

  // One full-adder cell per bit, carry rippling upward
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]  = a[i] ^ b_eff[i] ^ c[i];
      assign c[i+1]  = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
  endgenerate

  assign cout  = c[WIDTH];
  assign c_msb = c[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/au_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | au_seq_ctrl                                                        |
// | Sequencer for a shared 6-bit add/subtract unit: single-pass add/   |
// | sub, and unsigned multiply as shift-and-add iterations on the same |
// | adder. Results are registered; done is a one-cycle pulse.          |
// | Optional macro AU_SEQ_OVF_EN adds the signed overflow output ovf.  |
// | Revision: 1.0  initial release                                     |
// +------------------------------------------------------------------+
import au_seq_pkg::*;

module au_seq_ctrl #(
  parameter int WIDTH = au_seq_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
`ifdef AU_SEQ_OVF_EN
  output logic               ovf,
`endif
  output logic               carry
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

  state_t           state, state_n;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             add_sub, add_cin, add_cout, add_cmsb;
  logic [WIDTH-1:0] step_s;
  logic             step_c;
  logic             is_sub;
  logic             last_iter;

  assign is_sub    = (op_q == OP_SUB);
  assign last_iter = (cnt == LAST_ITER);
  assign busy      = (state != ST_IDLE);

  // Operand mux: MUL feeds the partial product and multiplicand, EXEC the captured operands
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_sub = is_sub;
    add_cin = is_sub;
    if (state == ST_MUL) begin
      add_x   = acc_hi;
      add_y   = mcand;
      add_sub = 1'b0;
      add_cin = 1'b0;
    end
  end

  au6_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (add_x),
    .b     (add_y),
    .sub   (add_sub),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout),
    .c_msb (add_cmsb)
  );

`ifndef AU_SEQ_OVF_EN
  logic unused_cmsb;
  assign unused_cmsb = add_cmsb;
`endif

  // Multiply step: add the multiplicand only when the current multiplier bit is set
  always_comb begin
    step_c = 1'b0;
    step_s = acc_hi;
    if (acc_lo[0]) begin
      step_c = add_cout;
      step_s = add_sum;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; reserved op takes the add path
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = (op == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_n = ST_IDLE;
      ST_MUL:  if (last_iter) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Operand capture, multiply accumulator shifting and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
`ifdef AU_SEQ_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            acc_hi <= '0;
            acc_lo <= b;
            mcand  <= a;
            cnt    <= '0;
          end
        end
        ST_EXEC: begin
          result <= {{WIDTH{1'b0}}, add_sum};
          carry  <= add_cout;
`ifdef AU_SEQ_OVF_EN
          ovf    <= add_cmsb ^ add_cout;
`endif
          done   <= 1'b1;
        end
        ST_MUL: begin
          acc_hi <= {step_c, step_s[WIDTH-1:1]};
          acc_lo <= {step_s[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            result <= {step_c, step_s, acc_lo[WIDTH-1:1]};
            carry  <= 1'b0;
`ifdef AU_SEQ_OVF_EN
            ovf    <= 1'b0;
`endif
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_au_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_au_seq_ctrl                                                     |
// | Directed-vector bench for au_seq_ctrl with hand-computed results.  |
// | Revision: 1.0  initial release                                     |
// +------------------------------------------------------------------+
module tb_au_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [5:0]  a, b;
  logic        busy, done, carry;
  logic [11:0] result;
`ifdef AU_SEQ_OVF_EN
  logic        ovf;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  au_seq_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef AU_SEQ_OVF_EN
    .ovf    (ovf),
`endif
    .carry  (carry)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request, let edge E0 accept it, then drop start
  task automatic launch(input logic [1:0] o, input logic [5:0] x, input logic [5:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [5:0] x,
                        input logic [5:0] y, input int lat, input logic [11:0] exp_res,
                        input logic exp_c, input logic exp_ovf);
    int n;
    launch(o, x, y);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_res"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_carry"}, 32'(carry), 32'(exp_c));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
`ifdef AU_SEQ_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) ;
`endif
    tick();
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_carry", 32'(carry), 32'd0);
`ifdef AU_SEQ_OVF_EN
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    tick();

    run_op("add", 2'b00, 6'd10, 6'd5, 1, 12'd15, 1'b0, 1'b0);
    run_op("sub_nb", 2'b01, 6'd10, 6'd5, 1, 12'd5, 1'b1, 1'b0);
    run_op("sub_b", 2'b01, 6'd5, 6'd10, 1, 12'd59, 1'b0, 1'b0);
    run_op("rsv_add", 2'b11, 6'd3, 6'd4, 1, 12'd7, 1'b0, 1'b0);
    run_op("mul_max", 2'b10, 6'd63, 6'd63, 6, 12'hF81, 1'b0, 1'b0);
    run_op("mul_zero", 2'b10, 6'd0, 6'd45, 6, 12'd0, 1'b0, 1'b0);
    run_op("mul_13x11", 2'b10, 6'd13, 6'd11, 6, 12'd143, 1'b0, 1'b0);
    run_op("add_wrap", 2'b00, 6'd63, 6'd1, 1, 12'd0, 1'b1, 1'b0);
    run_op("add_31_1", 2'b00, 6'd31, 6'd1, 1, 12'd32, 1'b0, 1'b1);

    // start pulsed during a multiply must be ignored
    launch(2'b10, 6'd63, 6'd63);
    tick();
    start = 1'b1; op = 2'b00; a = 6'd1; b = 6'd1;
    tick();
    start = 1'b0;
    wait_done(n);
    check_eq("ign_lat", 32'(n), 32'd4);
    check_eq("ign_res", 32'(result), 32'hF81);
    tick();
    check_eq("ign_no_restart", 32'(busy), 32'd0);
    tick();

    // start held through the done cycle: second op accepted straight away
    start = 1'b1; op = 2'b00; a = 6'd10; b = 6'd5;
    tick();
    op = 2'b01;
    tick();
    check_eq("b2b_done1", 32'(done), 32'd1);
    check_eq("b2b_res1", 32'(result), 32'd15);
    tick();
    start = 1'b0;
    check_eq("b2b_busy2", 32'(busy), 32'd1);
    check_eq("b2b_done_low", 32'(done), 32'd0);
    tick();
    check_eq("b2b_done2", 32'(done), 32'd1);
    check_eq("b2b_res2", 32'(result), 32'd5);
    check_eq("b2b_carry2", 32'(carry), 32'd1);
    tick();

    // reset mid-multiply at E3
    launch(2'b10, 6'd7, 6'd9);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("rmid_busy", 32'(busy), 32'd0);
    check_eq("rmid_done", 32'(done), 32'd0);
    check_eq("rmid_result", 32'(result), 32'd0);
    check_eq("rmid_carry", 32'(carry), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check_eq("rmid_no_done", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/au_seq_ctrl.md
# au_seq_ctrl

Sequencing controller for the 6-bit add/subtract unit. It accepts one operation at a time: add, subtract or unsigned multiply. Add and subtract complete in one pass through the adder. Multiply is performed as six shift-and-add iterations reusing the same adder. The block sits between a requesting datapath and the single shared add/subtract unit, and registers all results.

## Interface
- WIDTH, 6, operand width; result is 2*WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 add, 01 sub, 10 mul, 11 reserved (executes as add).
- a  in  WIDTH  operand A / multiplicand.
- b  in  WIDTH  operand B / multiplier.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse, result valid.
- result  out  2*WIDTH  registered result; holds until next done.
- carry  out  1  adder carry-out for add/sub (sub: 1 = no borrow); 0 for mul.

Clock is `clk`; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, EXEC (add/sub), MUL, and DONE-free return. done is a registered pulse emitted on the transition back to IDLE.
- IDLE: start=1 captures a, b and op.
  - add/sub goes to EXEC.
  - mul goes to MUL, with acc_hi=0, acc_lo=b, mcand=a, iteration count=0.
- EXEC: adder computes a ± b.
  - Sub uses one's-complement of b with carry-in 1.
  - result = {0s, sum}; carry = adder carry-out.
  - State goes to IDLE and done pulses.
- MUL, each iteration:
  - If acc_lo[0]=1, {c,s} = acc_hi + mcand (carry-in 0); otherwise {c,s} = {0, acc_hi}.
  - Then {acc_hi, acc_lo} <= {c, s, acc_lo[5:1]} and the count increments.
  - After iteration 6 (count was 5): result = {acc_hi, acc_lo}, carry=0, state goes to IDLE, done pulses.
- All arithmetic is unsigned and modulo 2^WIDTH on the adder. The product is exact (max 63*63 = 3969 fits in 12 bits).
- start while busy is ignored. Operands and op are not re-sampled mid-operation.
- Reset at any point:
  - State goes to IDLE; busy=0, done=0, result=0, carry=0.
  - An in-flight operation is discarded, with no done pulse.
- Reset values: busy 0, done 0, result 0, carry 0 (ovf 0 when compiled in).

## Timing
- Let E0 be the edge where start is sampled high in IDLE.
- add/sub:
  - busy high from E0 to E1.
  - result, carry and done update at E1; done is high for exactly the cycle after E1.
  - Latency is 1 cycle after acceptance.
- mul:
  - Iterations at E1..E6.
  - result and done at E6; busy high from E0 to E6.
  - Latency is 6 cycles after acceptance.
- busy and done are never high together.
- State is IDLE during the done cycle, so a new start held in the done cycle is accepted at the next edge (back-to-back, no bubble beyond done).

## Configuration
- AU_SEQ_OVF_EN defined:
  - Adds output ovf (1 bit), the signed two's-complement overflow of add/sub: carry into MSB XOR carry out of MSB, registered with result at EXEC completion.
  - ovf=0 for mul; ovf resets to 0.
- Not defined: no ovf port and no overflow logic.

## Structure
- Package au_seq_pkg holds:
  - the WIDTH default;
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_RSV;
  - the FSM state encoding;
  - MUL_ITERS=6.
- Sub-module au6_addsub: WIDTH-bit ripple add/subtract unit with inputs a, b, sub and carry-in, and outputs sum, carry-out and MSB carry-in (the last feeds ovf). It is instantiated once and shared by EXEC and MUL, with an operand mux selecting b vs mcand and acc_hi vs a.

## Test plan
- Add: op=00, a=10, b=5 → done one cycle after E0; result=15; carry=0; ovf=0.
- Sub without borrow: op=01, a=10, b=5 → result=5, carry=1.
- Sub with borrow: op=01, a=5, b=10 → result=59 (6'b111011), carry=0.
- Multiply edge values:
  - op=10, a=63, b=63 → busy for 6 cycles; done at E6; result=3969 (12'hF81); carry=0.
  - a=0, b=45 → result 0.
- Start handling:
  - start pulsed at E2 during a mul with different operands → ignored; result still the original product.
  - Start held through the done cycle → second operation accepted immediately.
- Reset mid-mul at E3 → IDLE next cycle, all outputs 0, no done pulse.
- With AU_SEQ_OVF_EN: 31+1 → ovf=1; 63+1 → result=0, carry=1, ovf=0.
